// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and types for the two-port ALU arbiter.
//   DW / OPW / CW   : operand/result, opcode and op-counter widths
//   OP_*            : opcode encodings understood by alu_core
//   DEFAULT_RESULT  : result returned for any unassigned opcode
//   GT_TRUE         : result of OP_GT when A > B
//   arb_state_t     : arbiter control states
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DW  = 5;
   localparam int OPW = 4;
   localparam int CW  = 8;

   localparam logic [OPW-1:0] OP_NAND = 4'b1101;
   localparam logic [OPW-1:0] OP_XOR  = 4'b1100;
   localparam logic [OPW-1:0] OP_SHL2 = 4'b0111;
   localparam logic [OPW-1:0] OP_ROTB = 4'b0101;
   localparam logic [OPW-1:0] OP_MAX  = 4'b0001;
   localparam logic [OPW-1:0] OP_GT   = 4'b0000;

   localparam logic [DW-1:0] DEFAULT_RESULT = 5'b00110;
   localparam logic [DW-1:0] GT_TRUE        = 5'b01111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      HOLD = 2'b10
   } arb_state_t;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational 5-bit unsigned ALU.
//   op_i     : opcode (see alu_pkg OP_*)
//   a_i, b_i : operands
//   result_o : result, DW bits, overflow bits dropped
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
(
   input  logic [OPW-1:0] op_i,
   input  logic [DW-1:0]  a_i,
   input  logic [DW-1:0]  b_i,
   output logic [DW-1:0]  result_o
);

   // Opcode decode and datapath select
   always_comb begin
      result_o = DEFAULT_RESULT;
      case (op_i)
         OP_NAND: result_o = ~(a_i & b_i);
         OP_XOR:  result_o = a_i ^ b_i;
         // Shift left by two keeping only the low DW bits
         OP_SHL2: result_o = {a_i[2:0], 2'b00};
         // Rotate B left by one
         OP_ROTB: result_o = {b_i[3:0], b_i[4]};
         // Ties return B, which equals A anyway
         OP_MAX:  result_o = (a_i > b_i) ? a_i : b_i;
         OP_GT:   result_o = (a_i > b_i) ? GT_TRUE : 5'b00000;
         default: result_o = DEFAULT_RESULT;
      endcase
   end

endmodule : alu_core

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one alu_core between two requesters with round-robin arbitration.
// An accepted request is latched, executed in the following cycle and its
// result is held on a tagged output channel until the consumer takes it.
//   clk, rst                   : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b    : request channel of requester N (N = 0, 1)
//   out_valid/ready/data/id    : result channel, out_id = issuing requester
//   busy                       : high while an operation is in EXEC or HOLD
//   op_count                   : completed result handshakes, wraps
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic           out_id,
   output logic           busy,
   output logic [CW-1:0]  op_count
);

   arb_state_t     state_q, state_d;
   logic           rr_ptr_q, rr_ptr_d;
   logic [OPW-1:0] op_q, op_d;
   logic [DW-1:0]  a_q, a_d;
   logic [DW-1:0]  b_q, b_d;
   logic           id_q, id_d;
   logic           out_valid_q, out_valid_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic           out_id_q, out_id_d;
   logic           busy_q;
   logic [CW-1:0]  op_count_q, op_count_d;

   logic           can_accept_s;
   logic           gnt_valid_s;
   logic           gnt_id_s;
   logic           accept_s;
   logic [DW-1:0]  alu_result_s;

   alu_core u_alu_core (
      .op_i     (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_result_s)
   );

   // Round-robin grant: the pointer only breaks ties between two valid requests
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = rr_ptr_q;
      end else if (req0_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b0;
      end else if (req1_valid) begin
         gnt_valid_s = 1'b1;
         gnt_id_s    = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_id_s    = 1'b0;
      end
   end

   // A new request may enter when idle, or when the held result leaves this cycle
   assign can_accept_s = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
   assign accept_s     = can_accept_s && gnt_valid_s;
   assign req0_ready   = accept_s && !gnt_id_s;
   assign req1_ready   = accept_s && gnt_id_s;

   // Next-state, operand latch, result register and counter update
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      op_count_d  = op_count_q;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            out_data_d  = alu_result_s;
            out_id_d    = id_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               op_count_d  = op_count_q + {{(CW-1){1'b0}}, 1'b1};
               out_valid_d = 1'b0;
               if (accept_s) begin
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      // Operands are sampled only at the accept handshake
      if (accept_s) begin
         op_d     = gnt_id_s ? req1_op : req0_op;
         a_d      = gnt_id_s ? req1_a  : req0_a;
         b_d      = gnt_id_s ? req1_b  : req0_b;
         id_d     = gnt_id_s;
         rr_ptr_d = ~gnt_id_s;
      end else begin
         op_d     = op_q;
         a_d      = a_q;
         b_d      = b_q;
         id_d     = id_q;
         rr_ptr_d = rr_ptr_q;
      end
   end

   // State and datapath registers; reset drops any in-flight or held result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 1'b0;
         op_q        <= 4'b0000;
         a_q         <= 5'b00000;
         b_q         <= 5'b00000;
         id_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 5'b00000;
         out_id_q    <= 1'b0;
         busy_q      <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         // busy is registered from the next state so it equals (state != IDLE)
         busy_q      <= (state_d != IDLE);
         op_count_q  <= op_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign busy      = busy_q;
   assign op_count  = op_count_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a transaction-level model (queue of
// pending results with their due cycle) checked every cycle, plus directed
// scenarios with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1, out_ready;
   logic       req0_ready, req1_ready;
   logic [3:0] op0, op1;
   logic [4:0] a0, b0, a1, b1;
   logic       out_valid, out_id, busy;
   logic [4:0] out_data;
   logic [7:0] op_count;

   int checks = 0;
   int errors = 0;

   alu_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v0),
      .req0_ready (req0_ready),
      .req0_op    (op0),
      .req0_a     (a0),
      .req0_b     (b0),
      .req1_valid (v1),
      .req1_ready (req1_ready),
      .req1_op    (op1),
      .req1_a     (a1),
      .req1_b     (b1),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id),
      .busy       (busy),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU written with plain integer arithmetic
   function automatic logic [4:0] model_alu(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (op)
         4'b1101: return 5'(31 - (ia & ib));
         4'b1100: return 5'(ia ^ ib);
         4'b0111: return 5'((ia * 4) % 32);
         4'b0101: return 5'(((ib * 2) % 32) + (ib / 16));
         4'b0001: return 5'((ia > ib) ? ia : ib);
         4'b0000: return (ia > ib) ? 5'd15 : 5'd0;
         default: return 5'd6;
      endcase
   endfunction

   // Transaction model: each accepted request becomes due two cycles later
   typedef struct {
      logic       id;
      logic [4:0] data;
      int         due;
   } ent_t;

   ent_t q[$];
   int   cyc   = 0;
   int   m_cnt = 0;
   logic m_rr  = 1'b0;
   bit   live  = 1'b0;
   logic exp_ov, can, gv, g;

   always @(negedge clk) begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].due);
      can    = (q.size() == 0) || (exp_ov && out_ready);
      gv     = v0 || v1;
      g      = (v0 && v1) ? m_rr : !v0;
      if (live) begin
         chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
         chk("m_busy", 32'(busy), 32'(q.size() > 0));
         chk("m_op_count", 32'(op_count), 32'(m_cnt % 256));
         if (exp_ov) begin
            chk("m_out_data", 32'(out_data), 32'(q[0].data));
            chk("m_out_id", 32'(out_id), 32'(q[0].id));
         end
         if (!rst) begin
            chk("m_req0_ready", 32'(req0_ready), 32'(can && gv && !g));
            chk("m_req1_ready", 32'(req1_ready), 32'(can && gv && g));
         end
      end
      if (rst) begin
         q.delete();
         m_rr  = 1'b0;
         m_cnt = 0;
         live  = 1'b1;
      end else if (live) begin
         if (exp_ov && out_ready) begin
            void'(q.pop_front());
            m_cnt++;
         end
         if (can && gv) begin
            q.push_back('{id: g,
                          data: g ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0),
                          due: cyc + 2});
            m_rr = !g;
         end
      end
      cyc++;
   end

   time last_acc_t, last_out_t;

   // Present a request on port p and wait (bounded) for it to be accepted
   task automatic issue(input int p, input logic [3:0] op, input logic [4:0] a, input logic [4:0] b);
      int   n;
      logic got;
      if (p == 0) begin
         op0 = op; a0 = a; b0 = b; v0 = 1'b1;
      end else begin
         op1 = op; a1 = a; b1 = b; v1 = 1'b1;
      end
      n   = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         got = (p == 0) ? req0_ready : req1_ready;
      end
      last_acc_t = $time;
      chk("issue_accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      if (p == 0) v0 = 1'b0;
      else        v1 = 1'b0;
   endtask

   // Wait (bounded) for out_valid and compare against hand-computed values
   task automatic expect_result(input string name, input logic [4:0] d, input logic id);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (out_valid !== 1'b1 && n < 20);
      last_out_t = $time;
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(d));
      chk({name, "_id"}, 32'(out_id), 32'(id));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [3:0] t2_op [7] = '{4'b1100, 4'b0111, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b1111};
   logic [4:0] t2_a  [7] = '{5'b10101, 5'b00111, 5'b00000, 5'b00011, 5'b01001, 5'b01010, 5'b00001};
   logic [4:0] t2_b  [7] = '{5'b01100, 5'b00000, 5'b10010, 5'b01001, 5'b00011, 5'b01010, 5'b00010};
   logic [4:0] t2_r  [7] = '{5'b11001, 5'b11100, 5'b00101, 5'b01001, 5'b01111, 5'b00000, 5'b00110};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   seq [4];
      int   k;
      int   n;
      time  t0;
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; out_ready = 1'b0;
      op0 = 4'b0; op1 = 4'b0; a0 = 5'b0; b0 = 5'b0; a1 = 5'b0; b1 = 5'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: reset state, then a single request
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      @(posedge clk);
      #1;
      issue(0, 4'b1101, 5'b10101, 5'b01100);
      expect_result("t1", 5'b11011, 1'b0);
      chk("t1_latency", 32'((last_out_t - last_acc_t) / 10), 32'd2);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("t1_op_count", 32'(op_count), 32'd1);
      @(posedge clk);
      #1;

      // 2: opcode sweep through port 1
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         issue(1, t2_op[i], t2_a[i], t2_b[i]);
         expect_result($sformatf("t2_op%0d", i), t2_r[i], 1'b1);
         @(posedge clk);
         #1;
      end

      // 3: contention, both requesters valid for four grants
      do_reset();
      out_ready = 1'b1;
      op0 = 4'b1100; a0 = 5'b00001; b0 = 5'b00010;
      op1 = 4'b0001; a1 = 5'b00011; b1 = 5'b00100;
      v0 = 1'b1;
      v1 = 1'b1;
      k = 0;
      n = 0;
      while (k < 4 && n < 40) begin
         @(negedge clk);
         n++;
         if (req0_ready) begin
            seq[k] = 0;
            k++;
         end else if (req1_ready) begin
            seq[k] = 1;
            k++;
         end
      end
      @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
      chk("t3_grants", 32'(k), 32'd4);
      chk("t3_g0", 32'(seq[0]), 32'd0);
      chk("t3_g1", 32'(seq[1]), 32'd1);
      chk("t3_g2", 32'(seq[2]), 32'd0);
      chk("t3_g3", 32'(seq[3]), 32'd1);
      repeat (4) @(posedge clk);
      #1;

      // 4: back-pressure with a pending request
      out_ready = 1'b0;
      issue(0, 4'b1100, 5'b10101, 5'b01100);
      expect_result("t4_first", 5'b11001, 1'b0);
      @(posedge clk);
      #1;
      op0 = 4'b0000; a0 = 5'b01001; b0 = 5'b00011; v0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_data", 32'(out_data), 32'h19);
         chk("t4_hold_id", 32'(out_id), 32'd0);
         chk("t4_hold_ready0", 32'(req0_ready), 32'd0);
         chk("t4_hold_busy", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t4_swap_ready0", 32'(req0_ready), 32'd1);
      chk("t4_swap_valid", 32'(out_valid), 32'd1);
      t0 = $time;
      @(posedge clk);
      #1;
      v0 = 1'b0;
      expect_result("t4_second", 5'b01111, 1'b0);
      chk("t4_latency", 32'((last_out_t - t0) / 10), 32'd2);
      @(posedge clk);
      #1;

      // 5a: reset while in EXEC, with the pointer pointing at port 1
      issue(0, 4'b1100, 5'b00001, 5'b00011);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5e_out_valid", 32'(out_valid), 32'd0);
      chk("t5e_busy", 32'(busy), 32'd0);
      chk("t5e_op_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5e_no_result", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      op0 = 4'b1100; a0 = 5'b00001; b0 = 5'b00011;
      op1 = 4'b1111; a1 = 5'b00000; b1 = 5'b00000;
      v0 = 1'b1;
      v1 = 1'b1;
      @(negedge clk);
      chk("t5e_rr_ready0", 32'(req0_ready), 32'd1);
      chk("t5e_rr_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
      expect_result("t5e_drain", 5'b00010, 1'b0);
      @(posedge clk);
      #1;

      // 5b: reset while in HOLD
      out_ready = 1'b0;
      issue(0, 4'b1100, 5'b00001, 5'b00011);
      expect_result("t5h_held", 5'b00010, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5h_out_valid", 32'(out_valid), 32'd0);
      chk("t5h_busy", 32'(busy), 32'd0);
      chk("t5h_op_count", 32'(op_count), 32'd0);
      @(posedge clk);
      #1;
      v0 = 1'b1;
      v1 = 1'b1;
      @(negedge clk);
      chk("t5h_rr_ready0", 32'(req0_ready), 32'd1);
      @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
      expect_result("t5h_drain", 5'b00010, 1'b0);
      @(posedge clk);
      #1;

      // 6: op counter wraps after 256 completed handshakes
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         issue(i % 2, 4'b1100, 5'(i), 5'b00011);
      end
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("t6_wrap", 32'(op_count), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_arbiter
